// File: rtl/mem_types_pkg.sv
// Shared memory-system types for the instruction cache and
// its mem_controller fill port.
package mem_types_pkg;

   typedef logic [31:0] word_t;
   typedef logic [12:0] block_addr_t;

   localparam int ICACHE_SETS        = 16;
   localparam int ICACHE_INDEX_WIDTH = 4;
   localparam int ICACHE_TAG_WIDTH   = 9;

   typedef enum logic {
      READY = 1'b0,
      MISS  = 1'b1
   } icache_state_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped 16-set instruction cache, 2-word lines,
// combinational lookup with single blocking fill from imem.
module icache
   import mem_types_pkg::*;
(
   input  logic              CLK,
   input  logic              nRST,
   output logic              DUT_error,
   input  logic              icache_REN,
   input  logic [15:0]       icache_addr,
   output logic              icache_hit,
   output word_t             icache_load,
   input  logic              icache_invalidate,
   output logic              imem_REN,
   output block_addr_t       imem_block_addr,
   input  logic              imem_hit,
   input  word_t [1:0]       imem_load
);

   icache_state_t                 r_state;
   block_addr_t                   r_miss_addr;
   logic [ICACHE_SETS-1:0]        r_valid;
   logic [ICACHE_TAG_WIDTH-1:0]   r_tag  [ICACHE_SETS];
   word_t                         r_data [ICACHE_SETS][2];
   logic                          r_error;

   block_addr_t                   w_blk;
   logic [ICACHE_INDEX_WIDTH-1:0] w_index;
   logic [ICACHE_TAG_WIDTH-1:0]   w_tag;
   logic [ICACHE_INDEX_WIDTH-1:0] w_fill_index;
   logic                          w_lookup;
   logic                          w_fill;
   logic                          w_bypass;
   logic                          w_unused_addr;

   assign w_blk         = icache_addr[15:3];
   assign w_index       = w_blk[ICACHE_INDEX_WIDTH-1:0];
   assign w_tag         = w_blk[12:ICACHE_INDEX_WIDTH];
   assign w_fill_index  = r_miss_addr[ICACHE_INDEX_WIDTH-1:0];
   assign w_unused_addr = ^icache_addr[1:0];

   assign w_lookup = r_valid[w_index] && (r_tag[w_index] == w_tag);
   assign w_fill   = (r_state == MISS) && imem_hit;
   assign w_bypass = w_fill && (w_blk == r_miss_addr);

   // Invalidate masks every hit source, including the fill bypass.
   assign icache_hit = icache_REN && !icache_invalidate
                     && (w_lookup || w_bypass);

   always_comb begin
      icache_load = '0;
      if (icache_hit) begin
         if (w_bypass)
            icache_load = imem_load[icache_addr[2]];
         else
            icache_load = r_data[w_index][icache_addr[2]];
      end
   end

   assign imem_REN        = (r_state == MISS);
   assign imem_block_addr = (r_state == MISS) ? r_miss_addr : '0;
   assign DUT_error       = r_error;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state     <= READY;
         r_miss_addr <= '0;
         r_valid     <= '0;
         r_error     <= 1'b0;
      end else begin
         r_error <= (r_state == READY) && imem_hit;
         if (icache_invalidate)
            r_valid <= '0;
         unique case (r_state)
            READY: begin
               if (icache_REN && !w_lookup && !icache_invalidate) begin
                  r_state     <= MISS;
                  r_miss_addr <= w_blk;
               end
            end
            MISS: begin
               // Fill lands after the clear so its line stays valid.
               if (imem_hit) begin
                  r_state               <= READY;
                  r_valid[w_fill_index] <= 1'b1;
               end
            end
            default: r_state <= READY;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (w_fill) begin
         r_tag[w_fill_index]     <= r_miss_addr[12:ICACHE_INDEX_WIDTH];
         r_data[w_fill_index][0] <= imem_load[0];
         r_data[w_fill_index][1] <= imem_load[1];
      end
   end

endmodule
